// File: rtl/exp_sum_normalizer_pkg.sv
// Shared Q-format constants and FSM state type for the softmax exp-sum normaliser.
package softmax_pkg;
    localparam int EXP_FRAC_BITS = 7;
    localparam int M_W           = 7;
    localparam logic [M_W-1:0] M_HALF = 7'h40;
    localparam int NORM_EXP_W    = 6;

    typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;
endpackage

// File: rtl/exp_sum_normalizer_if.sv
// Input element stream and normalised result handshake of exp_sum_normalizer.
interface exp_sum_normalizer_if #(
    parameter int EXP_W   = 8,
    parameter int VEC_LEN = 16
);
    import softmax_pkg::*;
    localparam int CNT_W = $clog2(VEC_LEN) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_W-1:0]      in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [M_W-1:0]        m_value;
    logic [NORM_EXP_W-1:0] norm_exp;
    logic                  sum_zero;
    logic                  len_err;
    logic [CNT_W-1:0]      elem_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, m_value, norm_exp, sum_zero, len_err, elem_count
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, m_value, norm_exp, sum_zero, len_err, elem_count
    );
endinterface

// File: rtl/exp_sum_normalizer_lead_one_enc.sv
// Priority encoder: position of the most significant set bit plus an all-zero flag.
module lead_one_enc #(
    parameter int W  = 12,
    parameter int LW = $clog2(W)
) (
    input  logic [W-1:0]  val,
    output logic [LW-1:0] pos,
    output logic          zero
);
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++)
            if (val[i]) pos = LW'(i);
        zero = ~|val;
    end
endmodule

// File: rtl/exp_sum_normalizer.sv
// Accumulates a vector of Q1.7 exp values and emits sum = (m/128) * 2^norm_exp, m in [0.5,1).
// Optional EXPSUM_ROUND_EN: round-to-nearest on the mantissa instead of truncation.
module exp_sum_normalizer
    import softmax_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int VEC_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    exp_sum_normalizer_if.slave bus
);
    localparam int SUM_W = EXP_W + $clog2(VEC_LEN);
    localparam int LW    = $clog2(SUM_W);
    localparam int CNT_W = $clog2(VEC_LEN) + 1;

    state_t                state, state_nxt;
    logic [SUM_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic [LW-1:0]         pos;
    logic                  acc_zero;
    logic                  accept;
    logic [LW-1:0]         shamt;
    logic [M_W-1:0]        m_nxt;
    logic [NORM_EXP_W-1:0] ne_raw, ne_nxt;

    lead_one_enc #(.W(SUM_W)) u_lead (.val(acc), .pos(pos), .zero(acc_zero));

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ACCUM;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && (bus.in_last || cnt == CNT_W'(VEC_LEN - 1))) state_nxt = NORM;
            NORM:  state_nxt = OUT;
            OUT:   if (bus.out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM) && !rst;
        bus.out_valid = (state == OUT);
    end

    // Left-justify the leading one at SUM_W-1; the mantissa is then the top M_W bits,
    // which covers both truncation (p >= 6) and zero-fill (p < 6).
    assign shamt  = LW'(SUM_W - 1) - pos;
    assign ne_raw = NORM_EXP_W'(pos) - NORM_EXP_W'(EXP_FRAC_BITS - 1);

`ifdef EXPSUM_ROUND_EN
    logic [M_W:0] top8, m_rnd;
    always_comb begin
        top8  = (M_W+1)'((acc << shamt) >> (SUM_W - M_W - 1));
        m_rnd = {1'b0, top8[M_W:1]} + (M_W+1)'(top8[0]);
        // Carry out of the mantissa renormalises to 0.5 one octave up.
        if (m_rnd[M_W]) begin
            m_nxt  = M_HALF;
            ne_nxt = ne_raw + NORM_EXP_W'(1);
        end else begin
            m_nxt  = m_rnd[M_W-1:0];
            ne_nxt = ne_raw;
        end
    end
`else
    always_comb begin
        m_nxt  = M_W'((acc << shamt) >> (SUM_W - M_W));
        ne_nxt = ne_raw;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc            <= '0;
            cnt            <= '0;
            bus.len_err    <= 1'b0;
            bus.m_value    <= M_HALF;
            bus.norm_exp   <= '0;
            bus.sum_zero   <= 1'b0;
            bus.elem_count <= '0;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    acc <= acc + SUM_W'(bus.in_data);
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(VEC_LEN - 1) && !bus.in_last) bus.len_err <= 1'b1;
                end
                NORM: begin
                    bus.m_value    <= acc_zero ? M_HALF : m_nxt;
                    bus.norm_exp   <= acc_zero ? '0 : ne_nxt;
                    bus.sum_zero   <= acc_zero;
                    bus.elem_count <= cnt;
                end
                OUT: if (bus.out_ready) begin
                    acc         <= '0;
                    cnt         <= '0;
                    bus.len_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
